omp_frame_collector: RTL and testbench
======================================

Name: omp_frame_collector

Overview:
- Receiving end of the OMP reconstruction pixel-write interface (`pixel_we`/`pixel_addr`/`pixel_val`/`done_all`) produced by `omp_system_top`.
- Captures sparse, out-of-order pixel writes into a 64-entry frame buffer.
- On `done_all`, streams the complete frame in ascending address order over a valid/ready interface (to a UART/display/host bridge).
- Pixels never written during the frame are emitted as zero.

Parameters:
- ADDR_W, 6, pixel address width; frame depth = 2**ADDR_W (64 for the 8x8 image).
- DATA_W, 24, pixel value width.
- CNT_W, 8, frame counter width.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- pixel_we  in  1  pixel write strobe from the reconstruction core.
- pixel_addr  in  ADDR_W  pixel address, valid when pixel_we=1.
- pixel_val  in  DATA_W  pixel value, valid when pixel_we=1.
- done_all  in  1  end-of-frame pulse from the reconstruction core.
- m_valid  out  1  output beat valid.
- m_ready  in  1  downstream accepts beat.
- m_data  out  DATA_W  pixel value (0 if unwritten).
- m_addr  out  ADDR_W  pixel address of current beat.
- m_last  out  1  high on the address-(DEPTH-1) beat.
- busy  out  1  high while the frame drains.
- pix_count  out  ADDR_W+1  distinct addresses written in the current frame.
- frame_cnt  out  CNT_W  completed frames, wraps.
- dup_err  out  1  sticky: same address written twice in one frame.
- drop_err  out  1  sticky: pixel_we seen while draining.

Behaviour:
- Storage:
  - DEPTH x DATA_W array with asynchronous read.
  - DEPTH-bit written mask; the array itself is never cleared.
- States: CAPTURE (reset state), DRAIN.
- Reset (rst=1 at a clk edge):
  - state=CAPTURE, mask=0, drain index=0, pix_count=0, frame_cnt=0, dup_err=0, drop_err=0.
  - Outputs m_valid=0, m_last=0, busy=0. m_addr and m_data are driven from index 0, so m_data=0.
  - Reset applied mid-DRAIN aborts the stream immediately; no m_last is issued and frame_cnt does not increment.
- CAPTURE, pixel_we=1:
  - mem[addr]<=val, mask[addr]<=1.
  - If mask[addr] was 0: pix_count+1.
  - If mask[addr] was 1: dup_err<=1, the new value overwrites the old, pix_count unchanged.
- CAPTURE, done_all=1 at edge T:
  - DRAIN from T+1, with m_valid=1, busy=1, index=0.
  - A pixel_we at the same edge T is captured first and appears in the drained frame.
  - Latency from done_all to first valid beat is 1 cycle.
- DRAIN, outputs:
  - m_addr=index.
  - m_data = mask[index] ? mem[index] : 0.
  - m_last = (index==DEPTH-1).
  - m_valid stays 1 continuously in DRAIN.
- DRAIN, handshake:
  - A beat transfers when m_valid & m_ready at a clk edge; index+1 on transfer.
  - With m_ready=0, m_addr/m_data/m_last hold stable.
  - Full-throughput drain with m_ready=1 takes DEPTH cycles.
- DRAIN, last-beat transfer:
  - Next cycle: state=CAPTURE, m_valid=0, busy=0, mask cleared, pix_count=0, index=0, frame_cnt+1 (wraps at 2**CNT_W).
- DRAIN, ignored and dropped inputs:
  - done_all is ignored.
  - pixel_we is dropped: memory and mask are unchanged, drop_err<=1.
- CAPTURE with no writes followed by done_all: streams DEPTH zero beats normally.
- dup_err and drop_err clear only on rst.

Test Plan:
- Full frame: write all 64 addresses in reverse order with val=addr*0x010101, then done_all, m_ready=1 -> first m_valid 1 cycle after done_all; 64 consecutive beats with m_addr 0..63 and m_data=addr*0x010101; m_last only at addr 63; pix_count=64 before drain; frame_cnt=1; busy falls the cycle after the last beat.
- Sparse frame: write addr 3=0xABCDEF and addr 40=0x123456 only -> drain shows those values at 3 and 40, 0x000000 elsewhere; pix_count=2.
- Backpressure: m_ready pattern 1,0,0,1 repeating -> no beat lost or duplicated; data/addr/last stable while m_ready=0; total 64 transfers.
- Duplicate and same-cycle events: write addr 5=0x111111 then addr 5=0x222222; on a later cycle write addr 9=0x0000FF together with done_all -> dup_err=1, pix_count=2, drain shows 0x222222 at 5 and 0x0000FF at 9.
- Drop and next frame: pixel_we addr 7=0xFFFFFF during DRAIN -> drop_err=1; after the drain, a second done_all with no writes streams all zeros (mask cleared, addr 7 not written); frame_cnt=2.
- Reset mid-drain: assert rst at beat 20 -> next cycle m_valid=0, busy=0, frame_cnt=0, pix_count=0, errors cleared; a subsequent done_all streams 64 zero beats.

Source files
------------

// File: rtl/omp_frame_collector.sv
// Frame collector for the OMP reconstruction pixel-write interface: captures sparse
// pixel writes into a frame buffer, then streams the whole frame over valid/ready.
module omp_frame_collector #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 24,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pixel_we,
  input  logic [ADDR_W-1:0] pixel_addr,
  input  logic [DATA_W-1:0] pixel_val,
  input  logic              done_all,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [ADDR_W-1:0] m_addr,
  output logic              m_last,
  output logic              busy,
  output logic [ADDR_W:0]   pix_count,
  output logic [CNT_W-1:0]  frame_cnt,
  output logic              dup_err,
  output logic              drop_err
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] PREV_IDX = ADDR_W'(DEPTH - 2);

  typedef enum logic {CAPTURE = 1'b0, DRAIN = 1'b1} state_t;

  state_t            state;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  mask;
  logic [ADDR_W-1:0] idx;
  logic              cap_we;

  assign cap_we = (state == CAPTURE) && pixel_we && !rst;

  // Array is never cleared; validity of each entry comes from the written mask.
  always_ff @(posedge clk) begin
    if (cap_we) begin
      mem[pixel_addr] <= pixel_val;
    end
  end

  assign m_addr = idx;
  assign m_data = mask[idx] ? mem[idx] : '0;

  // Capture/drain state machine with registered handshake and status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= CAPTURE;
      mask      <= '0;
      idx       <= '0;
      pix_count <= '0;
      frame_cnt <= '0;
      dup_err   <= 1'b0;
      drop_err  <= 1'b0;
      m_valid   <= 1'b0;
      m_last    <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        CAPTURE: begin
          if (pixel_we) begin
            mask[pixel_addr] <= 1'b1;
            if (mask[pixel_addr]) begin
              dup_err <= 1'b1;
            end else begin
              pix_count <= pix_count + (ADDR_W+1)'(1);
            end
          end
          // A same-edge write is captured above, so it lands in this frame.
          if (done_all) begin
            state   <= DRAIN;
            m_valid <= 1'b1;
            busy    <= 1'b1;
            idx     <= '0;
            m_last  <= (DEPTH == 1);
          end
        end
        DRAIN: begin
          if (pixel_we) begin
            drop_err <= 1'b1;
          end
          if (m_ready) begin
            if (idx == LAST_IDX) begin
              state     <= CAPTURE;
              m_valid   <= 1'b0;
              busy      <= 1'b0;
              m_last    <= 1'b0;
              mask      <= '0;
              pix_count <= '0;
              idx       <= '0;
              frame_cnt <= frame_cnt + CNT_W'(1);
            end else begin
              idx    <= idx + ADDR_W'(1);
              m_last <= (idx == PREV_IDX);
            end
          end
        end
        default: begin
          state <= CAPTURE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_omp_frame_collector.sv
// Directed self-checking bench for omp_frame_collector: table-driven capture phases
// plus hand-written drain, backpressure, drop and mid-drain reset sequences.
module tb_omp_frame_collector;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pixel_we = 1'b0;
  logic [5:0]  pixel_addr = 6'd0;
  logic [23:0] pixel_val = 24'd0;
  logic        done_all = 1'b0;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [23:0] m_data;
  logic [5:0]  m_addr;
  logic        m_last;
  logic        busy;
  logic [6:0]  pix_count;
  logic [7:0]  frame_cnt;
  logic        dup_err;
  logic        drop_err;

  int checks = 0;
  int errors = 0;
  logic [23:0] exp_frame [64];
  int exp_frames = 0;

  always #5 clk = ~clk;

  omp_frame_collector dut (
    .clk(clk), .rst(rst), .pixel_we(pixel_we), .pixel_addr(pixel_addr),
    .pixel_val(pixel_val), .done_all(done_all), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_addr(m_addr), .m_last(m_last), .busy(busy),
    .pix_count(pix_count), .frame_cnt(frame_cnt), .dup_err(dup_err), .drop_err(drop_err)
  );

  typedef struct {
    logic        rst;
    logic        we;
    logic [5:0]  addr;
    logic [23:0] val;
    logic        done;
    logic        exp_valid;
    logic        exp_busy;
    logic        exp_dup;
    logic [6:0]  exp_pix;
    logic [23:0] exp_data;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are read there too.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic clear_exp();
    for (int i = 0; i < 64; i++) exp_frame[i] = 24'd0;
  endtask

  task automatic run_vecs(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      rst = vecs[i].rst; pixel_we = vecs[i].we; pixel_addr = vecs[i].addr;
      pixel_val = vecs[i].val; done_all = vecs[i].done;
      step();
      check($sformatf("vec%0d_valid", i), 32'(m_valid), 32'(vecs[i].exp_valid));
      check($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].exp_busy));
      check($sformatf("vec%0d_dup", i), 32'(dup_err), 32'(vecs[i].exp_dup));
      check($sformatf("vec%0d_pix", i), 32'(pix_count), 32'(vecs[i].exp_pix));
      check($sformatf("vec%0d_data", i), 32'(m_data), 32'(vecs[i].exp_data));
    end
    rst = 1'b0; pixel_we = 1'b0; done_all = 1'b0;
  endtask

  task automatic write_pix(input logic [5:0] a, input logic [23:0] v);
    pixel_we = 1'b1; pixel_addr = a; pixel_val = v;
    step();
    pixel_we = 1'b0;
    exp_frame[a] = v;
  endtask

  task automatic kick();
    done_all = 1'b1;
    step();
    done_all = 1'b0;
    check("first_valid", 32'(m_valid), 32'd1);
  endtask

  // mode 0: m_ready always 1; mode 1: pattern 1,0,0,1. Stops early at stop_beat (reset test).
  task automatic drain(input int mode, input bit inject_drop, input int stop_beat);
    int beat = 0;
    int cyc = 0;
    while (beat < stop_beat && cyc < 400) begin
      m_ready = (mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
      check($sformatf("valid_b%0d", beat), 32'(m_valid), 32'd1);
      check($sformatf("busy_b%0d", beat), 32'(busy), 32'd1);
      check($sformatf("addr_b%0d", beat), 32'(m_addr), 32'(beat));
      check($sformatf("data_b%0d", beat), 32'(m_data), 32'(exp_frame[beat]));
      check($sformatf("last_b%0d", beat), 32'(m_last), 32'(beat == 63));
      pixel_we = inject_drop && (beat == 10);
      pixel_addr = 6'd7; pixel_val = 24'hFFFFFF;
      if (stop_beat < 64 && beat == stop_beat - 1) m_ready = 1'b1;
      step();
      if (m_ready) beat++;
      cyc++;
    end
    pixel_we = 1'b0;
    m_ready = 1'b0;
    check("drain_beats", 32'(beat), 32'(stop_beat));
    if (stop_beat == 64) begin
      exp_frames++;
      check("end_valid", 32'(m_valid), 32'd0);
      check("end_busy", 32'(busy), 32'd0);
      check("end_last", 32'(m_last), 32'd0);
      check("end_pix", 32'(pix_count), 32'd0);
      check("end_frames", 32'(frame_cnt), 32'(exp_frames));
    end
  endtask

  initial begin
    //              rst   we    addr   val          done  valid busy  dup   pix   data
    vecs[0] = '{1'b1, 1'b0, 6'd0,  24'h000000, 1'b0, 1'b0, 1'b0, 1'b0, 7'd0, 24'h0};
    vecs[1] = '{1'b1, 1'b1, 6'd3,  24'h555555, 1'b0, 1'b0, 1'b0, 1'b0, 7'd0, 24'h0};
    vecs[2] = '{1'b0, 1'b1, 6'd3,  24'hABCDEF, 1'b0, 1'b0, 1'b0, 1'b0, 7'd1, 24'h0};
    vecs[3] = '{1'b0, 1'b1, 6'd40, 24'h123456, 1'b0, 1'b0, 1'b0, 1'b0, 7'd2, 24'h0};
    vecs[4] = '{1'b0, 1'b0, 6'd0,  24'h000000, 1'b0, 1'b0, 1'b0, 1'b0, 7'd2, 24'h0};
    vecs[5] = '{1'b0, 1'b0, 6'd0,  24'h000000, 1'b1, 1'b1, 1'b1, 1'b0, 7'd2, 24'h0};
    vecs[6] = '{1'b0, 1'b1, 6'd5,  24'h111111, 1'b0, 1'b0, 1'b0, 1'b0, 7'd1, 24'h0};
    vecs[7] = '{1'b0, 1'b1, 6'd5,  24'h222222, 1'b0, 1'b0, 1'b0, 1'b1, 7'd1, 24'h0};
    vecs[8] = '{1'b0, 1'b0, 6'd0,  24'h000000, 1'b0, 1'b0, 1'b0, 1'b1, 7'd1, 24'h0};
    vecs[9] = '{1'b0, 1'b1, 6'd9,  24'h0000FF, 1'b1, 1'b1, 1'b1, 1'b1, 7'd2, 24'h0};

    step();
    run_vecs(0, 1);
    check("rst_frames", 32'(frame_cnt), 32'd0);
    check("rst_last", 32'(m_last), 32'd0);
    check("rst_drop", 32'(drop_err), 32'd0);

    // Sparse frame
    clear_exp();
    exp_frame[3] = 24'hABCDEF; exp_frame[40] = 24'h123456;
    run_vecs(2, 5);
    drain(0, 1'b0, 64);

    // Full frame, reverse order, full throughput
    clear_exp();
    for (int a = 63; a >= 0; a--) write_pix(6'(a), 24'(a) * 24'h010101);
    check("full_pix", 32'(pix_count), 32'd64);
    kick();
    drain(0, 1'b0, 64);

    // Same frame under backpressure
    for (int a = 63; a >= 0; a--) write_pix(6'(a), 24'(a) * 24'h010101);
    kick();
    drain(1, 1'b0, 64);

    // Duplicate write plus write together with done_all, with a drop during drain
    clear_exp();
    exp_frame[5] = 24'h222222; exp_frame[9] = 24'h0000FF;
    run_vecs(6, 9);
    check("pre_drop", 32'(drop_err), 32'd0);
    drain(0, 1'b1, 64);
    check("drop_err", 32'(drop_err), 32'd1);
    check("dup_sticky", 32'(dup_err), 32'd1);

    // Empty frame: mask cleared and the dropped write to 7 never landed
    clear_exp();
    kick();
    drain(0, 1'b0, 64);

    // Reset at beat 20
    for (int a = 0; a < 64; a++) write_pix(6'(a), 24'hC0FFEE);
    kick();
    drain(0, 1'b0, 20);
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_frames = 0;
    check("mid_rst_valid", 32'(m_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_frames", 32'(frame_cnt), 32'd0);
    check("mid_rst_pix", 32'(pix_count), 32'd0);
    check("mid_rst_dup", 32'(dup_err), 32'd0);
    check("mid_rst_drop", 32'(drop_err), 32'd0);
    check("mid_rst_addr", 32'(m_addr), 32'd0);
    check("mid_rst_data", 32'(m_data), 32'd0);
    step();
    check("post_rst_idle", 32'(m_valid), 32'd0);
    clear_exp();
    kick();
    drain(0, 1'b0, 64);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
